// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage core: drives PC and pipeline-register enables,
// runs the ecall halt drain, and keeps saturating stall/flush counters.
module pipeline_control_unit #(
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             is_stall,
   input  logic             branch_mispredict,
   input  logic             icache_ready,
   input  logic             mem_req,
   input  logic             dcache_ready,
   input  logic             halt_req,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic             mem_wb_write,
   output logic             is_halted,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int unsigned DcntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

   typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

   state_e             state_q;
   logic [DcntW-1:0]   dcnt_q;
   logic               is_halted_q;
   logic [CNT_W-1:0]   stall_cnt_q;
   logic [CNT_W-1:0]   flush_cnt_q;

   logic freeze;
   logic stall_inc;
   logic flush_inc;
   logic halt_accept;

   assign freeze = mem_req & ~dcache_ready;

   always_comb begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      halt_accept  = 1'b0;
      if (!reset) begin
         unique case (state_q)
            StRun: begin
               if (freeze) begin
                  // Whole pipe holds; pending mispredict/stall is re-evaluated next cycle.
                  stall_inc = 1'b1;
               end else if (branch_mispredict) begin
                  pc_write     = 1'b1;
                  if_id_write  = 1'b1;
                  if_id_flush  = 1'b1;
                  id_ex_write  = 1'b1;
                  id_ex_flush  = 1'b1;
                  ex_mem_write = 1'b1;
                  mem_wb_write = 1'b1;
                  flush_inc    = 1'b1;
               end else if (is_stall) begin
                  id_ex_write  = 1'b1;
                  id_ex_flush  = 1'b1;
                  ex_mem_write = 1'b1;
                  mem_wb_write = 1'b1;
                  stall_inc    = 1'b1;
               end else if (!icache_ready || halt_req) begin
                  // Fetch bubble or ecall acceptance: IF/ID takes a NOP, ID advances.
                  if_id_write  = 1'b1;
                  if_id_flush  = 1'b1;
                  id_ex_write  = 1'b1;
                  ex_mem_write = 1'b1;
                  mem_wb_write = 1'b1;
                  stall_inc    = 1'b1;
                  halt_accept  = icache_ready;
               end else begin
                  pc_write     = 1'b1;
                  if_id_write  = 1'b1;
                  id_ex_write  = 1'b1;
                  ex_mem_write = 1'b1;
                  mem_wb_write = 1'b1;
               end
            end
            StDrain: begin
               if_id_flush  = 1'b1;
               id_ex_flush  = 1'b1;
               if_id_write  = ~freeze;
               id_ex_write  = ~freeze;
               ex_mem_write = ~freeze;
               mem_wb_write = ~freeze;
            end
            StHalted: begin
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StRun;
         dcnt_q      <= '0;
         is_halted_q <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (halt_accept) begin
                  state_q <= StDrain;
                  dcnt_q  <= DcntW'(DRAIN_CYCLES);
               end
            end
            StDrain: begin
               if (!freeze) begin
                  if (dcnt_q == '0) begin
                     state_q     <= StHalted;
                     is_halted_q <= 1'b1;
                  end else begin
                     dcnt_q <= dcnt_q - DcntW'(1);
                  end
               end
            end
            StHalted: begin
            end
            default: state_q <= StRun;
         endcase
         if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign is_halted   = is_halted_q;
   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed-vector bench: driver pushes hand-computed expectations, negedge monitor compares.
module tb_pipeline_control_unit;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic is_stall = 1'b0, branch_mispredict = 1'b0, icache_ready = 1'b1;
   logic mem_req = 1'b0, dcache_ready = 1'b1, halt_req = 1'b0;

   logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_write;
   logic is_halted;
   logic [31:0] stall_count, flush_count;

   logic pc_write4, if_id_write4, if_id_flush4, id_ex_write4, id_ex_flush4;
   logic ex_mem_write4, mem_wb_write4, is_halted4;
   logic [3:0] stall_count4, flush_count4;

   always #5 clk = ~clk;

   pipeline_control_unit dut (
      .clk(clk), .reset(reset), .is_stall(is_stall), .branch_mispredict(branch_mispredict),
      .icache_ready(icache_ready), .mem_req(mem_req), .dcache_ready(dcache_ready),
      .halt_req(halt_req), .pc_write(pc_write), .if_id_write(if_id_write),
      .if_id_flush(if_id_flush), .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
      .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write), .is_halted(is_halted),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   pipeline_control_unit #(.DRAIN_CYCLES(2), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .is_stall(is_stall), .branch_mispredict(branch_mispredict),
      .icache_ready(icache_ready), .mem_req(mem_req), .dcache_ready(dcache_ready),
      .halt_req(halt_req), .pc_write(pc_write4), .if_id_write(if_id_write4),
      .if_id_flush(if_id_flush4), .id_ex_write(id_ex_write4), .id_ex_flush(id_ex_flush4),
      .ex_mem_write(ex_mem_write4), .mem_wb_write(mem_wb_write4), .is_halted(is_halted4),
      .stall_count(stall_count4), .flush_count(flush_count4)
   );

   // Enable vector order: {pc, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_w}
   localparam logic [6:0] EN_0    = 7'b0000000;
   localparam logic [6:0] EN_RUN  = 7'b1101011;
   localparam logic [6:0] EN_MIS  = 7'b1111111;
   localparam logic [6:0] EN_STL  = 7'b0001111;
   localparam logic [6:0] EN_IMISS = 7'b0111011;
   localparam logic [6:0] EN_HALT = 7'b0111011;
   localparam logic [6:0] EN_DRN  = 7'b0111111;
   localparam logic [6:0] EN_DFRZ = 7'b0010100;
   localparam logic [6:0] M_ALL   = 7'h7F;
   localparam logic [6:0] M_WR    = 7'b1101011;

   typedef struct {
      logic [6:0] en;
      logic [6:0] mask;
      logic       halted;
      int         sc;
      int         fc;
      bit         chk4;
      int         sc4;
      string      name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int checks = 0;
   int failures = 0;
   logic [6:0] act_en;

   task automatic step(input logic r, st, bm, ic, mr, dr, hr, input logic [6:0] en,
                       input logic [6:0] mask, input logic h, input int sc, input int fc,
                       input bit chk4, input int sc4, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      reset = r; is_stall = st; branch_mispredict = bm; icache_ready = ic;
      mem_req = mr; dcache_ready = dr; halt_req = hr;
      e.en = en; e.mask = mask; e.halted = h; e.sc = sc; e.fc = fc;
      e.chk4 = chk4; e.sc4 = sc4; e.name = nm;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         act_en = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                   ex_mem_write, mem_wb_write};
         checks++;
         if ((act_en & mon_e.mask) !== (mon_e.en & mon_e.mask)) begin
            failures++;
            $display("FAIL %s enables: got %b want %b (mask %b)", mon_e.name, act_en,
                     mon_e.en, mon_e.mask);
         end
         checks++;
         if (is_halted !== mon_e.halted) begin
            failures++;
            $display("FAIL %s is_halted: got %b want %b", mon_e.name, is_halted, mon_e.halted);
         end
         checks++;
         if (stall_count !== 32'(mon_e.sc)) begin
            failures++;
            $display("FAIL %s stall_count: got %0d want %0d", mon_e.name, stall_count, mon_e.sc);
         end
         checks++;
         if (flush_count !== 32'(mon_e.fc)) begin
            failures++;
            $display("FAIL %s flush_count: got %0d want %0d", mon_e.name, flush_count, mon_e.fc);
         end
         if (mon_e.chk4) begin
            checks++;
            if (stall_count4 !== 4'(mon_e.sc4)) begin
               failures++;
               $display("FAIL %s stall_count(W4): got %0d want %0d", mon_e.name, stall_count4,
                        mon_e.sc4);
            end
         end
      end
   end

   initial begin
      //    r  st bm ic mr dr hr  en        mask   h  sc fc c4 sc4 name
      step(1, 0, 0, 1, 0, 1, 0, EN_0,     M_ALL, 0, 0, 0, 0, 0, "reset0");
      step(1, 0, 0, 1, 0, 1, 0, EN_0,     M_ALL, 0, 0, 0, 0, 0, "reset1");
      step(0, 0, 0, 1, 0, 1, 0, EN_RUN,   M_ALL, 0, 0, 0, 0, 0, "idle0");
      step(0, 0, 0, 1, 0, 1, 0, EN_RUN,   M_ALL, 0, 0, 0, 0, 0, "idle1");
      step(0, 0, 0, 1, 0, 1, 0, EN_RUN,   M_ALL, 0, 0, 0, 0, 0, "idle2");
      step(0, 1, 0, 1, 0, 1, 0, EN_STL,   M_ALL, 0, 0, 0, 0, 0, "stall");
      step(0, 0, 0, 1, 0, 1, 0, EN_RUN,   M_ALL, 0, 1, 0, 0, 0, "post_stall");
      step(0, 1, 1, 1, 0, 1, 0, EN_MIS,   M_ALL, 0, 1, 0, 0, 0, "mis_and_stall");
      step(0, 0, 0, 1, 0, 1, 0, EN_RUN,   M_ALL, 0, 1, 1, 0, 0, "post_mis");
      step(0, 0, 0, 0, 0, 1, 0, EN_IMISS, M_ALL, 0, 1, 1, 0, 0, "icache_miss");
      step(0, 0, 0, 1, 0, 1, 0, EN_RUN,   M_ALL, 0, 2, 1, 0, 0, "post_imiss");
      step(1, 0, 0, 1, 0, 1, 0, EN_0,     M_ALL, 0, 2, 1, 0, 0, "reset_a");
      step(0, 0, 0, 1, 0, 1, 0, EN_RUN,   M_ALL, 0, 0, 0, 0, 0, "idle_a");
      step(0, 0, 1, 1, 1, 0, 0, EN_0,     M_ALL, 0, 0, 0, 0, 0, "freeze_mis0");
      step(0, 0, 1, 1, 1, 0, 0, EN_0,     M_ALL, 0, 1, 0, 0, 0, "freeze_mis1");
      step(0, 0, 1, 1, 1, 0, 0, EN_0,     M_ALL, 0, 2, 0, 0, 0, "freeze_mis2");
      step(0, 0, 1, 1, 1, 1, 0, EN_MIS,   M_ALL, 0, 3, 0, 0, 0, "mis_actioned");
      step(0, 0, 0, 1, 0, 1, 0, EN_RUN,   M_ALL, 0, 3, 1, 0, 0, "post_freeze_mis");
      step(1, 0, 0, 1, 0, 1, 0, EN_0,     M_ALL, 0, 3, 1, 0, 0, "reset_b");
      step(0, 0, 0, 1, 0, 1, 0, EN_RUN,   M_ALL, 0, 0, 0, 0, 0, "idle_b");
      step(0, 0, 0, 1, 0, 1, 1, EN_HALT,  M_ALL, 0, 0, 0, 0, 0, "halt_t");
      step(0, 1, 1, 1, 0, 1, 1, EN_DRN,   M_ALL, 0, 1, 0, 0, 0, "drain1_ignore");
      step(0, 0, 0, 1, 0, 1, 0, EN_DRN,   M_ALL, 0, 1, 0, 0, 0, "drain2");
      step(0, 0, 0, 1, 0, 1, 0, EN_DRN,   M_ALL, 0, 1, 0, 0, 0, "drain3");
      step(0, 0, 1, 1, 0, 1, 1, EN_0,     M_ALL, 1, 1, 0, 0, 0, "halted_t4");
      step(0, 0, 0, 1, 0, 1, 0, EN_0,     M_ALL, 1, 1, 0, 0, 0, "halted_hold");
      step(1, 0, 0, 1, 0, 1, 0, EN_0,     M_ALL, 1, 1, 0, 0, 0, "reset_c");
      step(0, 0, 0, 1, 0, 1, 0, EN_RUN,   M_ALL, 0, 0, 0, 0, 0, "idle_c");
      step(0, 0, 0, 1, 0, 1, 1, EN_HALT,  M_ALL, 0, 0, 0, 0, 0, "halt2_t");
      step(0, 0, 0, 1, 0, 1, 0, EN_DRN,   M_ALL, 0, 1, 0, 0, 0, "halt2_drain1");
      step(0, 0, 0, 1, 1, 0, 0, EN_DFRZ,  M_WR,  0, 1, 0, 0, 0, "halt2_freeze1");
      step(0, 0, 0, 1, 1, 0, 0, EN_DFRZ,  M_WR,  0, 1, 0, 0, 0, "halt2_freeze2");
      step(0, 0, 0, 1, 0, 1, 0, EN_DRN,   M_ALL, 0, 1, 0, 0, 0, "halt2_drain2");
      step(0, 0, 0, 1, 0, 1, 0, EN_DRN,   M_ALL, 0, 1, 0, 0, 0, "halt2_drain3");
      step(0, 0, 0, 1, 0, 1, 0, EN_0,     M_ALL, 1, 1, 0, 0, 0, "halt2_halted");
      step(1, 0, 0, 1, 0, 1, 0, EN_0,     M_ALL, 1, 1, 0, 0, 0, "reset_d");
      step(0, 0, 0, 1, 0, 1, 0, EN_RUN,   M_ALL, 0, 0, 0, 0, 0, "idle_d");
      step(0, 0, 0, 1, 0, 1, 1, EN_HALT,  M_ALL, 0, 0, 0, 0, 0, "halt3_t");
      step(0, 0, 0, 1, 0, 1, 0, EN_DRN,   M_ALL, 0, 1, 0, 0, 0, "halt3_drain1");
      step(1, 0, 0, 1, 0, 1, 0, EN_0,     M_ALL, 0, 1, 0, 0, 0, "reset_mid_drain");
      step(0, 0, 0, 1, 0, 1, 0, EN_RUN,   M_ALL, 0, 0, 0, 0, 0, "run_after_reset0");
      step(0, 0, 0, 1, 0, 1, 0, EN_RUN,   M_ALL, 0, 0, 0, 0, 0, "run_after_reset1");
      step(1, 0, 0, 1, 0, 1, 0, EN_0,     M_ALL, 0, 0, 0, 0, 0, "reset_e");
      for (int i = 0; i < 18; i++) begin
         step(0, 1, 0, 1, 0, 1, 0, EN_STL, M_ALL, 0, i, 0, 1, (i > 15) ? 15 : i, "sat_stall");
      end
      step(0, 0, 0, 1, 0, 1, 0, EN_RUN,   M_ALL, 0, 18, 0, 1, 15, "sat_final");

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
